// File: rtl/tqv_peri_fabric_if.sv
// Core-side peripheral bus: address, write data and read/write strobes in; registered read data
// and the ready handshake out.
interface tqv_peri_fabric_if;
    logic [10:0] addr_in;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic        data_read_complete;
    logic [31:0] data_out;
    logic        data_ready;

    modport master (
        output addr_in,
        output data_in,
        output data_write_n,
        output data_read_n,
        output data_read_complete,
        input  data_out,
        input  data_ready
    );

    modport slave (
        input  addr_in,
        input  data_in,
        input  data_write_n,
        input  data_read_n,
        input  data_read_complete,
        output data_out,
        output data_ready
    );
endinterface

// File: rtl/tqv_peri_fabric.sv
// TinyQV peripheral fabric: address decode to user/byte slots, built-in GPIO + pin mux, read-return FSM.
// Reads take 1 cycle when the slot is ready, else wait up to TIMEOUT_CYCLES; writes complete the same cycle.
module tqv_peri_fabric #(
    parameter int          NUM_USER       = 16,
    parameter int          NUM_SIMPLE     = 16,
    parameter int          NUM_GPIO       = 8,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF,
    parameter int          UART_SLOT      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tqv_peri_fabric_if.slave        bus,
    input  logic [7:0]              ui_in,
    output logic [2*NUM_USER-1:0]   slot_write_n,
    output logic [2*NUM_USER-1:0]   slot_read_n,
    input  logic [32*NUM_USER-1:0]  slot_data,
    input  logic [NUM_USER-1:0]     slot_ready,
    input  logic [8*NUM_USER-1:0]   slot_uo,
    output logic [NUM_SIMPLE-1:0]   simple_write,
    input  logic [8*NUM_SIMPLE-1:0] simple_data,
    input  logic [8*NUM_SIMPLE-1:0] simple_uo,
    output logic [NUM_GPIO-1:0]     uo_out,
    output logic                    timeout_err
);

    if (NUM_USER < 2 || NUM_USER > 16) begin : g_bad_user
        $error("NUM_USER must be in 2..16");
    end
    if (NUM_SIMPLE < 1 || NUM_SIMPLE > 16) begin : g_bad_simple
        $error("NUM_SIMPLE must be in 1..16");
    end
    if (NUM_GPIO < 1 || NUM_GPIO > 8) begin : g_bad_gpio
        $error("NUM_GPIO must be in 1..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    // Flattened slot buses padded to 16 entries so a 4-bit index never leaves the array.
    logic [31:0] user_dat [16];
    logic        user_rdy [16];
    logic [7:0]  user_uo  [16];
    logic [7:0]  smp_dat  [16];
    logic [7:0]  smp_uo   [16];

    for (genvar s = 0; s < 16; s++) begin : g_pad
        if (s < NUM_USER) begin : g_user
            assign user_dat[s] = slot_data[s*32 +: 32];
            assign user_rdy[s] = slot_ready[s];
            assign user_uo[s]  = slot_uo[s*8 +: 8];
        end else begin : g_no_user
            assign user_dat[s] = '0;
            assign user_rdy[s] = 1'b0;
            assign user_uo[s]  = '0;
        end
        if (s < NUM_SIMPLE) begin : g_simple
            assign smp_dat[s] = simple_data[s*8 +: 8];
            assign smp_uo[s]  = simple_uo[s*8 +: 8];
        end else begin : g_no_simple
            assign smp_dat[s] = '0;
            assign smp_uo[s]  = '0;
        end
    end

    state_t              state;
    logic [7:0]          cnt;
    logic                data_ready_r;
    logic [NUM_GPIO-1:0] gpio_out;
    logic [4:0]          func_sel [8];

    logic       is_simple;
    logic [3:0] user_idx;
    logic [3:0] smp_idx;
    logic       user_hit;
    logic       smp_hit;
    logic       wr_req;
    logic       rd_req;
    logic       gpio_wr;
    logic       tmo_clr;
    logic       src_rdy;
    logic [31:0] src_dat;
    logic [31:0] gpio_rd;

    assign is_simple = bus.addr_in[10];
    assign user_idx  = bus.addr_in[9:6];
    assign smp_idx   = bus.addr_in[7:4];
    assign user_hit  = !is_simple && (int'(user_idx) < NUM_USER);
    assign smp_hit   = is_simple && (int'(smp_idx) < NUM_SIMPLE);
    assign wr_req    = bus.data_write_n != 2'b11;
    assign rd_req    = bus.data_read_n != 2'b11;
    assign gpio_wr   = wr_req && !is_simple && (user_idx == 4'd1);
    assign tmo_clr   = gpio_wr && (bus.addr_in[5:2] == 4'd2) && bus.data_in[0];

    assign bus.data_ready = data_ready_r | wr_req;

    // Only the low byte of write data ever lands in a register.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.data_in[31:8]};

    for (genvar s = 0; s < NUM_USER; s++) begin : g_strobe
        assign slot_write_n[2*s +: 2] = (user_hit && user_idx == 4'(s)) ? bus.data_write_n : 2'b11;
        assign slot_read_n[2*s +: 2]  = (user_hit && user_idx == 4'(s) && state != S_HOLD)
                                        ? bus.data_read_n : 2'b11;
    end

    for (genvar s = 0; s < NUM_SIMPLE; s++) begin : g_simple_wr
        assign simple_write[s] = wr_req && smp_hit && (smp_idx == 4'(s));
    end

    // Slot 1 register map, word-addressed.
    always_comb begin
        gpio_rd = '0;
        case (bus.addr_in[5:2])
            4'h0:    gpio_rd = 32'(gpio_out);
            4'h1:    gpio_rd = {24'd0, ui_in};
            4'h2:    gpio_rd = {31'd0, timeout_err};
            default: begin
                if (bus.addr_in[5] && int'(bus.addr_in[4:2]) < NUM_GPIO) begin
                    gpio_rd = {27'd0, func_sel[bus.addr_in[4:2]]};
                end
            end
        endcase
    end

    // Slot 0, slot 1, byte slots and unmapped indices are all ready immediately.
    always_comb begin
        src_rdy = 1'b1;
        src_dat = '0;
        if (is_simple) begin
            if (smp_hit) begin
                src_dat = {24'd0, smp_dat[smp_idx]};
            end
        end else if (user_hit) begin
            if (user_idx == 4'd1) begin
                src_dat = gpio_rd;
            end else if (user_idx != 4'd0) begin
                src_rdy = user_rdy[user_idx];
                src_dat = user_dat[user_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gpio_out <= '0;
            for (int i = 0; i < 8; i++) begin
                if (i < 2) begin
                    func_sel[i] <= 5'(UART_SLOT);
                end else if (i < NUM_GPIO) begin
                    func_sel[i] <= 5'd1;
                end else begin
                    func_sel[i] <= 5'd0;
                end
            end
        end else if (gpio_wr) begin
            if (bus.addr_in[5:2] == 4'd0) begin
                gpio_out <= bus.data_in[NUM_GPIO-1:0];
            end
            for (int i = 0; i < 8; i++) begin
                if (i < NUM_GPIO && bus.addr_in[5] && bus.addr_in[4:2] == 3'(i)) begin
                    func_sel[i] <= bus.data_in[4:0];
                end
            end
        end
    end

    // A timeout in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bus.data_out <= '0;
            data_ready_r <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            data_ready_r <= 1'b0;
            if (tmo_clr) begin
                timeout_err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (rd_req) begin
                        if (src_rdy) begin
                            bus.data_out <= src_dat;
                            data_ready_r <= 1'b1;
                            state        <= S_HOLD;
                        end else begin
                            cnt   <= '0;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!rd_req) begin
                        state <= S_IDLE;
                    end else if (src_rdy) begin
                        bus.data_out <= src_dat;
                        data_ready_r <= 1'b1;
                        state        <= S_HOLD;
                    end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        bus.data_out <= TIMEOUT_DATA;
                        data_ready_r <= 1'b1;
                        timeout_err  <= 1'b1;
                        state        <= S_HOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (bus.data_read_complete) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pin i picks bit i of the selected slot's output byte; slot 1 drives gpio_out.
    always_comb begin
        uo_out = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            if (func_sel[i][4]) begin
                if (int'(func_sel[i][3:0]) < NUM_SIMPLE) begin
                    uo_out[i] = smp_uo[func_sel[i][3:0]][i];
                end
            end else if (func_sel[i][3:0] == 4'd1) begin
                uo_out[i] = gpio_out[i];
            end else if (int'(func_sel[i][3:0]) < NUM_USER) begin
                uo_out[i] = user_uo[func_sel[i][3:0]][i];
            end
        end
    end

endmodule

// File: tb/tb_tqv_peri_fabric.sv
// Directed bench for tqv_peri_fabric with a transaction-level reference model checked every cycle.
module tb_tqv_peri_fabric;
    localparam int          NU = 16;
    localparam int          NS = 8;
    localparam int          NG = 8;
    localparam int          T  = 8;
    localparam logic [31:0] TD = 32'hDEADBEEF;
    localparam int          UART = 2;

    logic clk;
    logic rst_n;
    logic [7:0] ui_in;
    logic [2*NU-1:0]  slot_write_n, slot_read_n;
    logic [32*NU-1:0] slot_data_v;
    logic [NU-1:0]    slot_ready_v;
    logic [8*NU-1:0]  slot_uo_v;
    logic [NS-1:0]    simple_write;
    logic [8*NS-1:0]  simple_data_v, simple_uo_v;
    logic [NG-1:0]    uo_out;
    logic             timeout_err;

    logic [31:0] sd    [16];
    logic [7:0]  suo_u [16];
    logic [7:0]  sdat  [16];
    logic [7:0]  suo_s [16];
    int          s4_cnt = 0;

    tqv_peri_fabric_if bus ();

    tqv_peri_fabric #(
        .NUM_USER(NU), .NUM_SIMPLE(NS), .NUM_GPIO(NG),
        .TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TD), .UART_SLOT(UART)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ui_in(ui_in),
        .slot_write_n(slot_write_n), .slot_read_n(slot_read_n),
        .slot_data(slot_data_v), .slot_ready(slot_ready_v), .slot_uo(slot_uo_v),
        .simple_write(simple_write), .simple_data(simple_data_v), .simple_uo(simple_uo_v),
        .uo_out(uo_out), .timeout_err(timeout_err)
    );

    for (genvar s = 0; s < NU; s++) begin : g_upack
        assign slot_data_v[s*32 +: 32] = sd[s];
        assign slot_uo_v[s*8 +: 8]     = suo_u[s];
    end
    for (genvar s = 0; s < NS; s++) begin : g_spack
        assign simple_data_v[s*8 +: 8] = sdat[s];
        assign simple_uo_v[s*8 +: 8]   = suo_s[s];
    end

    // Slot 4 answers 3 cycles into a request, slot 5 never answers, the rest are always ready.
    always_comb begin
        slot_ready_v    = '1;
        slot_ready_v[5] = 1'b0;
        slot_ready_v[4] = (s4_cnt >= 3);
    end
    always @(posedge clk) s4_cnt <= (slot_read_n[9:8] != 2'b11) ? s4_cnt + 1 : 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file, outstanding-read age, held result.
    logic [7:0]  m_gpio;
    logic [4:0]  m_fsel [8];
    logic        m_err, m_hold, m_pulse;
    logic [31:0] m_dout;
    int          m_age;

    function automatic logic [31:0] model_reg(input logic [5:0] off);
        int w = int'(off[5:2]);
        if (w == 0) return {24'd0, m_gpio};
        if (w == 1) return {24'd0, ui_in};
        if (w == 2) return {31'd0, m_err};
        if (w >= 8) return {27'd0, m_fsel[w-8]};
        return 32'd0;
    endfunction

    function automatic logic [32:0] model_src(input logic [10:0] a);
        int ui = int'(a[9:6]);
        int si = int'(a[7:4]);
        if (a[10]) return (si < NS) ? {1'b1, 24'd0, sdat[si]} : {1'b1, 32'd0};
        if (ui >= NU || ui == 0) return {1'b1, 32'd0};
        if (ui == 1) return {1'b1, model_reg(a[5:0])};
        return {slot_ready_v[ui], sd[ui]};
    endfunction

    function automatic logic [7:0] model_uo();
        logic [7:0] r = '0;
        for (int p = 0; p < NG; p++) begin
            int src = int'(m_fsel[p][3:0]);
            if (m_fsel[p][4]) r[p] = (src < NS) ? suo_s[src][p] : 1'b0;
            else if (src == 1) r[p] = m_gpio[p];
            else r[p] = (src < NU) ? suo_u[src][p] : 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_strobe(input logic [1:0] code, input logic gate);
        logic [31:0] r = '1;
        if (!bus.addr_in[10] && gate) r[{bus.addr_in[9:6], 1'b0} +: 2] = code;
        return r;
    endfunction

    function automatic logic [7:0] model_swr();
        logic [7:0] r = '0;
        if (bus.addr_in[10] && int'(bus.addr_in[7:4]) < NS && bus.data_write_n != 2'b11)
            r[bus.addr_in[6:4]] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin : model_step
        logic [32:0] src;
        logic [10:0] a;
        a = bus.addr_in;
        if (!rst_n) begin
            m_gpio = '0; m_err = 1'b0; m_hold = 1'b0; m_pulse = 1'b0; m_dout = '0; m_age = 0;
            for (int i = 0; i < 8; i++) m_fsel[i] = (i < 2) ? 5'(UART) : 5'd1;
        end else begin
            src = model_src(a);
            if (bus.data_write_n != 2'b11 && !a[10] && a[9:6] == 4'd1) begin
                if (a[5:2] == 4'd0) m_gpio = bus.data_in[7:0];
                else if (a[5:2] == 4'd2 && bus.data_in[0]) m_err = 1'b0;
                else if (a[5]) m_fsel[a[4:2]] = bus.data_in[4:0];
            end
            m_pulse = 1'b0;
            if (m_hold) begin
                if (bus.data_read_complete) m_hold = 1'b0;
            end else if (bus.data_read_n != 2'b11) begin
                // Ready wins; otherwise a read left unanswered for T cycles after its request cycle times out.
                if (src[32]) begin
                    m_dout = src[31:0]; m_pulse = 1'b1; m_hold = 1'b1; m_age = 0;
                end else if (m_age == T) begin
                    m_dout = TD; m_err = 1'b1; m_pulse = 1'b1; m_hold = 1'b1; m_age = 0;
                end else begin
                    m_age++;
                end
            end else begin
                m_age = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_ready", {31'd0, bus.data_ready}, {31'd0, m_pulse | (bus.data_write_n != 2'b11)});
            chk("data_out", bus.data_out, m_dout);
            chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
            chk("uo_out", {24'd0, uo_out}, {24'd0, model_uo()});
            chk("slot_write_n", slot_write_n, model_strobe(bus.data_write_n, 1'b1));
            chk("slot_read_n", slot_read_n, model_strobe(bus.data_read_n, !m_hold));
            chk("simple_write", {24'd0, simple_write}, {24'd0, model_swr()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [10:0] a, input logic [31:0] d);
        bus.addr_in = a; bus.data_in = d; bus.data_write_n = 2'b10;
        tick();
        bus.data_write_n = 2'b11;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.data_ready && lat < 40);
        chk("read_handshake", {31'd0, bus.data_ready}, 32'd1);
    endtask

    task automatic do_read(input logic [10:0] a, output logic [31:0] d, output int lat);
        bus.addr_in = a; bus.data_read_n = 2'b10;
        wait_ready(lat);
        d = bus.data_out;
        bus.data_read_n = 2'b11; bus.data_read_complete = 1'b1;
        tick();
        bus.data_read_complete = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int lat;
        for (int s = 0; s < 16; s++) begin
            sd[s] = 32'h1000_0000 + 32'(s) * 32'h111;
            suo_u[s] = 8'(s * 17);
            sdat[s] = 8'h70 + 8'(s);
            suo_s[s] = 8'h00;
        end
        sd[4] = 32'h12345678; suo_u[2] = 8'h03; sdat[2] = 8'h7E;
        ui_in = 8'h5A;
        bus.addr_in = '0; bus.data_in = '0; bus.data_write_n = 2'b11;
        bus.data_read_n = 2'b11; bus.data_read_complete = 1'b0;
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        chk("rst_data_out", bus.data_out, 32'h0);
        chk("rst_data_ready", {31'd0, bus.data_ready}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_uo_out", {24'd0, uo_out}, 32'h03);

        // GPIO block lives at slot 1, base 0x040.
        do_write(11'h040, 32'hA5);
        chk("gpio_uo_out", {24'd0, uo_out}, 32'hA7);
        do_read(11'h040, d, lat);
        chk("gpio_rd_data", d, 32'hA5);
        chk("gpio_rd_lat", lat, 1);
        do_read(11'h044, d, lat);
        chk("ui_in_rd", d, 32'h5A);
        do_read(11'h000, d, lat);
        chk("slot0_rd", d, 32'h0);

        bus.addr_in = 11'h100; bus.data_read_n = 2'b10;
        wait_ready(lat);
        chk("s4_lat", lat, 4);
        chk("s4_data", bus.data_out, 32'h12345678);
        bus.data_read_n = 2'b11;
        sd[4] = 32'hCAFEF00D;
        tick();
        chk("s4_single_pulse", {31'd0, bus.data_ready}, 32'd0);
        tick(); tick();
        chk("s4_held", bus.data_out, 32'h12345678);
        bus.data_read_complete = 1'b1;
        tick();
        bus.data_read_complete = 1'b0;

        do_read(11'h140, d, lat);
        chk("tmo_data", d, 32'hDEADBEEF);
        chk("tmo_lat", lat, 9);
        chk("tmo_err_set", {31'd0, timeout_err}, 32'd1);
        do_read(11'h048, d, lat);
        chk("tmo_err_rd", d, 32'd1);
        do_write(11'h048, 32'd1);
        chk("tmo_err_clr", {31'd0, timeout_err}, 32'd0);

        do_write(11'h06C, 32'h13);
        suo_s[3] = 8'h08; #1;
        chk("pin3_simple_hi", {31'd0, uo_out[3]}, 32'd1);
        suo_s[3] = 8'h00; #1;
        chk("pin3_simple_lo", {31'd0, uo_out[3]}, 32'd0);
        do_write(11'h06C, 32'h1F);
        for (int s = 0; s < 16; s++) suo_s[s] = 8'hFF;
        #1;
        chk("pin3_out_of_range", {31'd0, uo_out[3]}, 32'd0);
        do_write(11'h070, 32'h04);
        chk("pin4_user4", {31'd0, uo_out[4]}, {31'd0, suo_u[4][4]});

        do_read(11'h420, d, lat);
        chk("byte_rd_data", d, 32'h0000007E);
        chk("byte_rd_lat", lat, 1);
        do_read(11'h4A0, d, lat);
        chk("byte_unmapped_rd", d, 32'h0);
        bus.addr_in = 11'h420; bus.data_in = 32'h55; bus.data_write_n = 2'b00; #1;
        chk("byte_wr_strobe", {24'd0, simple_write}, 32'h04);
        chk("byte_wr_ready", {31'd0, bus.data_ready}, 32'd1);
        tick();
        bus.data_write_n = 2'b11;

        bus.addr_in = 11'h140; bus.data_read_n = 2'b10;
        tick(); tick();
        rst_n = 1'b0; bus.data_read_n = 2'b11;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_read_ready", {31'd0, bus.data_ready}, 32'd0);
        tick();
        chk("rst_mid_read_no_pulse", {31'd0, bus.data_ready}, 32'd0);
        do_read(11'h06C, d, lat);
        chk("rst_fsel3", d, 32'd1);
        do_read(11'h060, d, lat);
        chk("rst_fsel0", d, 32'd2);
        do_read(11'h040, d, lat);
        chk("rst_gpio", d, 32'd0);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
